cpu_control_sequencer: RTL and testbench

Multi-cycle control unit for the 8-bit accumulator CPU. Steps through fetch, decode and execute states and drives the register-load, PC, ALU-select and memory strobes. Sits between the one-hot instruction decoder, whose 16-bit `decoded` output it consumes, and the datapath registers AR, PC, DR, TR, IR, R, AC and Z. Memory uses 16-bit addresses and 8-bit data. Instructions carrying an address operand (LDAC, STAC, JUMP, JMPZ, JPNZ) fetch two operand bytes, low byte first.

---
 rtl/cpu_pkg.sv | 56 +++++
 rtl/cpu_control_sequencer_if.sv | 29 ++
 rtl/cpu_ctrl_outdec.sv | 63 ++++++
 rtl/cpu_control_sequencer.sv | 73 +++++++
 tb/tb_cpu_control_sequencer.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared state, ALU-select and opcode definitions for the accumulator CPU control sequencer
package cpu_pkg;
    typedef enum logic [3:0] {
        FETCH1, FETCH2, FETCH3, DECODE, ADDR1, ADDR2, ADDR3,
        MEMRD, LOADAC, MEMWR1, MEMWR2, JMP, SKIP1, SKIP2
    } state_t;
    typedef enum logic [3:0] {
        ALU_PASS_DR, ALU_PASS_R, ALU_ADD, ALU_SUB, ALU_INC,
        ALU_CLR, ALU_AND, ALU_OR, ALU_XOR, ALU_NOT
    } alu_sel_t;
    typedef enum logic [1:0] {CLS_NONE, CLS_LDAC, CLS_STAC, CLS_JMP} op_cls_t;
    localparam int OP_NOP  = 0;
    localparam int OP_LDAC = 1;
    localparam int OP_STAC = 2;
    localparam int OP_MVAC = 3;
    localparam int OP_MOVR = 4;
    localparam int OP_JUMP = 5;
    localparam int OP_JMPZ = 6;
    localparam int OP_JPNZ = 7;
    localparam int OP_ADD  = 8;
    localparam int OP_SUB  = 9;
    localparam int OP_INAC = 10;
    localparam int OP_CLAC = 11;
    localparam int OP_AND  = 12;
    localparam int OP_OR   = 13;
    localparam int OP_XOR  = 14;
    localparam int OP_NOT  = 15;
    localparam logic [15:0] AC_MASK = 16'hFF10;
    localparam logic [15:0] Z_MASK  = 16'hFF00;
    typedef struct packed {
        logic     ar_ld;
        logic     ar_inc;
        logic     ar_src;
        logic     pc_ld;
        logic     pc_inc;
        logic     dr_ld;
        logic     dr_src;
        logic     tr_ld;
        logic     ir_ld;
        logic     r_ld;
        logic     ac_ld;
        logic     z_ld;
        logic     mem_rd;
        logic     mem_wr;
        alu_sel_t alu_sel;
    } strobes_t;
    function automatic alu_sel_t alu_of(input logic [15:0] d);
        return d[OP_MOVR] ? ALU_PASS_R : d[OP_ADD] ? ALU_ADD : d[OP_SUB] ? ALU_SUB :
               d[OP_INAC] ? ALU_INC : d[OP_CLAC] ? ALU_CLR : d[OP_AND] ? ALU_AND :
               d[OP_OR] ? ALU_OR : d[OP_XOR] ? ALU_XOR : d[OP_NOT] ? ALU_NOT : ALU_PASS_DR;
    endfunction
    function automatic op_cls_t cls_of(input logic [15:0] d);
        return d[OP_LDAC] ? CLS_LDAC : d[OP_STAC] ? CLS_STAC :
               (d[OP_JUMP] | d[OP_JMPZ] | d[OP_JPNZ]) ? CLS_JMP : CLS_NONE;
    endfunction
endpackage

// File: rtl/cpu_control_sequencer_if.sv
// cpu_control_sequencer_if: decoder/datapath side of the sequencer; mem_ready exists only with CPU_MEM_WAIT_EN
interface cpu_control_sequencer_if;
    import cpu_pkg::*;
    logic [15:0] decoded;
    logic        z;
`ifdef CPU_MEM_WAIT_EN
    logic        mem_ready;
`endif
    state_t      state;
    logic        ar_ld, ar_inc, ar_src, pc_ld, pc_inc, dr_ld, dr_src;
    logic        tr_ld, ir_ld, r_ld, ac_ld, z_ld, mem_rd, mem_wr;
    alu_sel_t    alu_sel;
    modport master (
        input  decoded, z,
`ifdef CPU_MEM_WAIT_EN
        input  mem_ready,
`endif
        output state, ar_ld, ar_inc, ar_src, pc_ld, pc_inc, dr_ld, dr_src,
        output tr_ld, ir_ld, r_ld, ac_ld, z_ld, mem_rd, mem_wr, alu_sel
    );
    modport slave (
        output decoded, z,
`ifdef CPU_MEM_WAIT_EN
        output mem_ready,
`endif
        input  state, ar_ld, ar_inc, ar_src, pc_ld, pc_inc, dr_ld, dr_src,
        input  tr_ld, ir_ld, r_ld, ac_ld, z_ld, mem_rd, mem_wr, alu_sel
    );
endinterface

// File: rtl/cpu_ctrl_outdec.sv
// cpu_ctrl_outdec: combinational state-to-strobe decoder; strobes are silenced while reset is high
module cpu_ctrl_outdec import cpu_pkg::*; (
    input  logic        reset,
    input  state_t      state,
    input  logic [15:0] decoded,
    input  logic        rdy,
    output strobes_t    s
);
    logic oh;
    assign oh = $onehot(decoded);
    always_comb begin
        s = '0;
        if (!reset) begin
            case (state)
                FETCH1: s.ar_ld = 1'b1;
                FETCH2: begin
                    s.mem_rd = 1'b1;
                    s.dr_ld  = rdy;
                    s.pc_inc = rdy;
                end
                FETCH3: begin
                    s.ir_ld = 1'b1;
                    s.ar_ld = 1'b1;
                end
                DECODE: begin
                    s.r_ld    = oh & decoded[OP_MVAC];
                    s.ac_ld   = oh & |(decoded & AC_MASK);
                    s.z_ld    = oh & |(decoded & Z_MASK);
                    s.alu_sel = s.ac_ld ? alu_of(decoded) : ALU_PASS_DR;
                end
                ADDR1: begin
                    s.mem_rd = 1'b1;
                    s.dr_ld  = rdy;
                    s.pc_inc = rdy;
                    s.ar_inc = rdy;
                end
                ADDR2: begin
                    s.mem_rd = 1'b1;
                    s.tr_ld  = rdy;
                    s.dr_ld  = rdy;
                    s.pc_inc = rdy;
                end
                ADDR3: begin
                    s.ar_ld  = 1'b1;
                    s.ar_src = 1'b1;
                end
                MEMRD: begin
                    s.mem_rd = 1'b1;
                    s.dr_ld  = rdy;
                end
                LOADAC: s.ac_ld = 1'b1;
                MEMWR1: begin
                    s.dr_ld  = 1'b1;
                    s.dr_src = 1'b1;
                end
                MEMWR2: s.mem_wr = 1'b1;
                JMP: s.pc_ld = 1'b1;
                SKIP1, SKIP2: s.pc_inc = 1'b1;
                default: s = '0;
            endcase
        end
    end
endmodule

// File: rtl/cpu_control_sequencer.sv
// cpu_control_sequencer: fetch/decode/execute FSM for the 8-bit accumulator CPU; CPU_MEM_WAIT_EN adds mem_ready wait states
module cpu_control_sequencer import cpu_pkg::*; (
    input logic                     clk,
    input logic                     reset,
    cpu_control_sequencer_if.master ctl
);
    state_t   state_q, state_d;
    op_cls_t  cls_q, cls_d;
    strobes_t s;
    logic     rdy, oh, go;
`ifdef CPU_MEM_WAIT_EN
    assign rdy = ctl.mem_ready;
`else
    assign rdy = 1'b1;
`endif
    assign oh = $onehot(ctl.decoded);
    assign go = ctl.decoded[OP_LDAC] | ctl.decoded[OP_STAC] | ctl.decoded[OP_JUMP] |
                (ctl.decoded[OP_JMPZ] & ctl.z) | (ctl.decoded[OP_JPNZ] & ~ctl.z);
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH1;
            cls_q   <= CLS_NONE;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
        end
    end
    // ADDR2/ADDR3 branch on the class latched in DECODE; decoded may change after that
    always_comb begin
        state_d = FETCH1;
        cls_d   = cls_q;
        case (state_q)
            FETCH1: state_d = FETCH2;
            FETCH2: state_d = rdy ? FETCH3 : FETCH2;
            FETCH3: state_d = DECODE;
            DECODE: begin
                cls_d   = oh ? cls_of(ctl.decoded) : CLS_NONE;
                state_d = !oh ? FETCH1 : go ? ADDR1 : (cls_d == CLS_JMP) ? SKIP1 : FETCH1;
            end
            ADDR1:  state_d = rdy ? ADDR2 : ADDR1;
            ADDR2:  state_d = !rdy ? ADDR2 : (cls_q == CLS_JMP) ? JMP : ADDR3;
            ADDR3:  state_d = (cls_q == CLS_LDAC) ? MEMRD : MEMWR1;
            MEMRD:  state_d = rdy ? LOADAC : MEMRD;
            MEMWR1: state_d = MEMWR2;
            MEMWR2: state_d = rdy ? FETCH1 : MEMWR2;
            SKIP1:  state_d = SKIP2;
            default: state_d = FETCH1;
        endcase
    end
    cpu_ctrl_outdec u_outdec (
        .reset   (reset),
        .state   (state_q),
        .decoded (ctl.decoded),
        .rdy     (rdy),
        .s       (s)
    );
    assign ctl.state   = state_q;
    assign ctl.ar_ld   = s.ar_ld;
    assign ctl.ar_inc  = s.ar_inc;
    assign ctl.ar_src  = s.ar_src;
    assign ctl.pc_ld   = s.pc_ld;
    assign ctl.pc_inc  = s.pc_inc;
    assign ctl.dr_ld   = s.dr_ld;
    assign ctl.dr_src  = s.dr_src;
    assign ctl.tr_ld   = s.tr_ld;
    assign ctl.ir_ld   = s.ir_ld;
    assign ctl.r_ld    = s.r_ld;
    assign ctl.ac_ld   = s.ac_ld;
    assign ctl.z_ld    = s.z_ld;
    assign ctl.mem_rd  = s.mem_rd;
    assign ctl.mem_wr  = s.mem_wr;
    assign ctl.alu_sel = s.alu_sel;
endmodule

// File: tb/tb_cpu_control_sequencer.sv
// tb_cpu_control_sequencer: randomized instruction streams checked cycle by cycle against a per-instruction micro-step model
module tb_cpu_control_sequencer;
    import cpu_pkg::*;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad = 0;
    localparam alu_sel_t ALU_OF[8] = '{ALU_ADD, ALU_SUB, ALU_INC, ALU_CLR, ALU_AND, ALU_OR, ALU_XOR, ALU_NOT};
    always #5 clk = ~clk;
    cpu_control_sequencer_if bus();
    cpu_control_sequencer dut (.clk(clk), .reset(reset), .ctl(bus));
    function automatic strobes_t observe();
        strobes_t a;
        a.ar_ld = bus.ar_ld;   a.ar_inc = bus.ar_inc; a.ar_src = bus.ar_src;
        a.pc_ld = bus.pc_ld;   a.pc_inc = bus.pc_inc; a.dr_ld = bus.dr_ld;
        a.dr_src = bus.dr_src; a.tr_ld = bus.tr_ld;   a.ir_ld = bus.ir_ld;
        a.r_ld = bus.r_ld;     a.ac_ld = bus.ac_ld;   a.z_ld = bus.z_ld;
        a.mem_rd = bus.mem_rd; a.mem_wr = bus.mem_wr; a.alu_sel = bus.alu_sel;
        return a;
    endfunction
    function automatic int op_index(input logic [15:0] d);
        int op = -1;
        if ($countones(d) == 1)
            for (int i = 0; i < 16; i++) if (d[i]) op = i;
        return op;
    endfunction
    // What each micro-step must drive, written straight from the per-state strobe lists
    function automatic strobes_t exp_strobes(input state_t st, input logic [15:0] d);
        strobes_t e = '0;
        int op = op_index(d);
        case (st)
            FETCH1: e.ar_ld = 1'b1;
            FETCH2: begin e.mem_rd = 1'b1; e.dr_ld = 1'b1; e.pc_inc = 1'b1; end
            FETCH3: begin e.ir_ld = 1'b1; e.ar_ld = 1'b1; end
            DECODE: begin
                if (op == OP_MVAC) e.r_ld = 1'b1;
                else if (op == OP_MOVR) begin e.ac_ld = 1'b1; e.alu_sel = ALU_PASS_R; end
                else if (op >= OP_ADD) begin e.ac_ld = 1'b1; e.z_ld = 1'b1; e.alu_sel = ALU_OF[op - OP_ADD]; end
            end
            ADDR1:  begin e.mem_rd = 1'b1; e.dr_ld = 1'b1; e.pc_inc = 1'b1; e.ar_inc = 1'b1; end
            ADDR2:  begin e.tr_ld = 1'b1; e.mem_rd = 1'b1; e.dr_ld = 1'b1; e.pc_inc = 1'b1; end
            ADDR3:  begin e.ar_ld = 1'b1; e.ar_src = 1'b1; end
            MEMRD:  begin e.mem_rd = 1'b1; e.dr_ld = 1'b1; end
            LOADAC: begin e.ac_ld = 1'b1; e.alu_sel = ALU_PASS_DR; end
            MEMWR1: begin e.dr_ld = 1'b1; e.dr_src = 1'b1; end
            MEMWR2: e.mem_wr = 1'b1;
            JMP:    e.pc_ld = 1'b1;
            SKIP1, SKIP2: e.pc_inc = 1'b1;
            default: e = '0;
        endcase
        return e;
    endfunction
    task automatic run_instr(input logic [15:0] d, input logic zv, input string tag);
        state_t   q[$];
        strobes_t e, a;
        int       op = op_index(d);
        q = '{FETCH1, FETCH2, FETCH3, DECODE};
        if (op == OP_LDAC) q = {q, ADDR1, ADDR2, ADDR3, MEMRD, LOADAC};
        else if (op == OP_STAC) q = {q, ADDR1, ADDR2, ADDR3, MEMWR1, MEMWR2};
        else if (op == OP_JUMP || (op == OP_JMPZ && zv) || (op == OP_JPNZ && !zv)) q = {q, ADDR1, ADDR2, JMP};
        else if (op == OP_JMPZ || op == OP_JPNZ) q = {q, SKIP1, SKIP2};
        foreach (q[i]) begin
            bus.decoded = (q[i] == DECODE) ? d : 16'($urandom);
            bus.z = (q[i] == DECODE) ? zv : 1'($urandom);
`ifdef CPU_MEM_WAIT_EN
            bus.mem_ready = 1'b1;
`endif
            #1;
            total++;
            if (bus.state !== q[i]) begin
                bad++;
                $display("FAIL %s step%0d state: got %0d want %0d (decoded=%h z=%b)", tag, i, bus.state, q[i], d, zv);
            end
            e = exp_strobes(q[i], d);
            a = observe();
            total++;
            if (a !== e) begin
                bad++;
                $display("FAIL %s step%0d strobes: got %h want %h (decoded=%h z=%b)", tag, i, a, e, d, zv);
            end
            @(negedge clk);
        end
    endtask
    task automatic test_reset();
        reset = 1'b1;
        repeat (3) begin
            bus.decoded = 16'($urandom);
            bus.z = 1'($urandom);
`ifdef CPU_MEM_WAIT_EN
            bus.mem_ready = 1'b1;
`endif
            @(negedge clk);
            total++;
            if (bus.state !== FETCH1) begin bad++; $display("FAIL reset state: got %0d want %0d", bus.state, FETCH1); end
            total++;
            if (observe() !== strobes_t'('0)) begin bad++; $display("FAIL reset strobes: got %h want 0", observe()); end
        end
        reset = 1'b0;
    endtask
    task automatic test_nop();  run_instr(16'h0001, 1'b0, "nop");  endtask
    task automatic test_add();  run_instr(16'h0100, 1'b1, "add");  endtask
    task automatic test_stac(); run_instr(16'h0004, 1'b0, "stac"); endtask
    task automatic test_jmpz();
        run_instr(16'h0040, 1'b0, "jmpz_nt");
        run_instr(16'h0040, 1'b1, "jmpz_t");
        run_instr(16'h0080, 1'b1, "jpnz_nt");
        run_instr(16'h0080, 1'b0, "jpnz_t");
    endtask
    task automatic test_bad_decode();
        run_instr(16'h0000, 1'b1, "zero_hot");
        run_instr(16'h0003, 1'b0, "multi_hot");
        run_instr(16'h8102, 1'b1, "multi_hot3");
    endtask
    task automatic test_random();
        logic [15:0] d;
        for (int n = 0; n < 80; n++) begin
            d = ($urandom_range(0, 7) == 0) ? 16'($urandom) : (16'h1 << $urandom_range(0, 15));
            run_instr(d, 1'($urandom), "random");
        end
    endtask
    task automatic test_reset_in_addr2();
        strobes_t e;
        bus.decoded = 16'h0002;
        bus.z = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        #1;
        total++;
        if (bus.state !== ADDR2) begin bad++; $display("FAIL rst_addr2 pre-state: got %0d want %0d", bus.state, ADDR2); end
        total++;
        if (observe() !== strobes_t'('0)) begin bad++; $display("FAIL rst_addr2 strobes: got %h want 0", observe()); end
        @(negedge clk);
        reset = 1'b0;
        #1;
        total++;
        if (bus.state !== FETCH1) begin bad++; $display("FAIL rst_addr2 next state: got %0d want %0d", bus.state, FETCH1); end
        e = exp_strobes(FETCH1, bus.decoded);
        total++;
        if (observe() !== e) begin bad++; $display("FAIL rst_addr2 fetch1 strobes: got %h want %h", observe(), e); end
    endtask
`ifdef CPU_MEM_WAIT_EN
    task automatic test_mem_wait();
        state_t w[13] = '{FETCH1, FETCH2, FETCH3, DECODE, ADDR1, ADDR2, ADDR3,
                          MEMRD, MEMRD, MEMRD, MEMRD, LOADAC, FETCH1};
        int nrd = 0;
        int ndr = 0;
        for (int c = 0; c < 13; c++) begin
            bus.decoded = 16'h0002;
            bus.z = 1'b0;
            bus.mem_ready = !(c >= 7 && c <= 9);
            #1;
            total++;
            if (bus.state !== w[c]) begin bad++; $display("FAIL wait step%0d state: got %0d want %0d", c, bus.state, w[c]); end
            if (c >= 7 && c <= 10) begin
                nrd += int'(bus.mem_rd);
                ndr += int'(bus.dr_ld);
            end
            if (c < 12) @(negedge clk);
        end
        total++;
        if (nrd != 4) begin bad++; $display("FAIL wait mem_rd cycles: got %0d want 4", nrd); end
        total++;
        if (ndr != 1) begin bad++; $display("FAIL wait dr_ld pulses: got %0d want 1", ndr); end
    endtask
`endif
    initial begin
        bus.decoded = '0;
        bus.z = 1'b0;
`ifdef CPU_MEM_WAIT_EN
        bus.mem_ready = 1'b1;
`endif
        test_reset();
        test_nop();
        test_add();
        test_jmpz();
        test_stac();
        test_bad_decode();
        test_random();
        test_reset_in_addr2();
`ifdef CPU_MEM_WAIT_EN
        test_mem_wait();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
